// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [5:0] DEFAULT_PATTERN = 6'b101011;

  // Width of a counter that indexes bits 0..w-1 (at least one bit).
  function automatic int unsigned bitcnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-out shift register; zeros shift in from the LSB end.
module seq_shift_reg #(
  parameter int PAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_load_val,
  output logic             o_msb
);

  logic [PAT_W-1:0] r_q;

  // Clear beats load beats shift; emptied register presents 0 on the MSB.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {r_q[PAT_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a pattern MSB-first, rep_cnt+1 times
// back-to-back, with a start/busy/done handshake.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [PAT_W-1:0] load_pat,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      BC_W     = bitcnt_w(PAT_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PAT_W - 1);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [BC_W-1:0]  r_bit;
  logic [CNT_W-1:0] r_copies;

  logic             w_last_bit;
  logic [PAT_W-1:0] w_src;
  logic             w_sr_load;
  logic             w_sr_clear;
  logic             w_sr_shift;
  logic [PAT_W-1:0] w_sr_val;
  logic             w_sr_msb;

  // A same-edge load_en supplies the pattern for the transmission it starts.
  assign w_src      = load_en ? load_pat : r_pat;
  assign w_last_bit = (r_bit == LAST_BIT);

  // Shift register control: load on start or on copy wrap, clear on abort.
  always_comb begin
    w_sr_load  = 1'b0;
    w_sr_clear = 1'b0;
    w_sr_shift = 1'b0;
    w_sr_val   = r_pat;
    case (r_state)
      IDLE: begin
        w_sr_load = start;
        w_sr_val  = w_src;
      end
      SHIFT: begin
        w_sr_clear = abort;
        w_sr_load  = w_last_bit && (r_copies != '0);
        w_sr_shift = 1'b1;
      end
      default: ;
    endcase
  end

  // The register's MSB is the serial bit; after the last bit it has shifted
  // out to all zeros, so out is 0 whenever out_valid is low.
  seq_shift_reg #(
    .PAT_W (PAT_W)
  ) u_sr (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_sr_clear),
    .i_load     (w_sr_load),
    .i_shift    (w_sr_shift),
    .i_load_val (w_sr_val),
    .o_msb      (w_sr_msb)
  );

  assign out = w_sr_msb;

  // Pattern register: writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= PATTERN;
    end else if (r_state == IDLE && load_en) begin
      r_pat <= load_pat;
    end
  end

  // Control FSM with bit/copy counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit     <= '0;
      r_copies  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= SHIFT;
            r_bit     <= '0;
            r_copies  <= rep_cnt;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state   <= IDLE;
            r_bit     <= '0;
            r_copies  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (w_last_bit) begin
            r_bit <= '0;
            if (r_copies != '0) begin
              r_copies <= r_copies - CNT_W'(1);
            end else begin
              r_state   <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            r_bit <= r_bit + BC_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a 101011 detector model on the serial output.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic [5:0] load_pat = '0;
  logic       start = 1'b0;
  logic [3:0] rep_cnt = '0;
  logic       abort = 1'b0;
  logic       out, out_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // Detector model state (written only by the monitor process).
  logic [5:0] hist = '0;
  int         vcnt = 0;
  int         det = 0;
  int         misal = 0;
  int         det0;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_W   (6),
    .PATTERN (6'b101011),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_pat  (load_pat),
    .start     (start),
    .rep_cnt   (rep_cnt),
    .abort     (abort),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  // Overlapping 101011 detector fed by valid serial bits.
  always @(negedge clk) begin
    logic [5:0] w;
    if (out_valid) begin
      w    = {hist[4:0], out};
      hist = w;
      vcnt = vcnt + 1;
      if (w == 6'b101011 && vcnt >= 6) begin
        det = det + 1;
        if (vcnt % 6 != 0) misal = misal + 1;
      end
    end else begin
      hist = '0;
      vcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a transmission at the next edge and checks every cycle through done.
  task automatic send(input string tag, input logic [5:0] exp_bits, input int copies,
                      input logic ld, input logic [5:0] lp, input logic [3:0] rc,
                      input int poke_at);
    logic b;
    start = 1'b1; load_en = ld; load_pat = lp; rep_cnt = rc;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    for (int i = 0; i < copies * 6; i++) begin
      b = exp_bits[5 - (i % 6)];
      chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_bit%0d", tag, i), out, b);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_nodone%0d", tag, i), done, 0);
      if (i == poke_at) begin
        start = 1'b1; load_en = 1'b1; load_pat = 6'b000000; rep_cnt = 4'hF;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; load_en = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_out"}, out, 0);
    chk({tag, "_done_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single copy of the default pattern
    send("single", 6'b101011, 1, 1'b0, 6'b0, 4'd0, -1);

    // Three back-to-back copies
    send("rep2", 6'b101011, 3, 1'b0, 6'b0, 4'd2, -1);

    // start/load_en pulsed mid-stream are ignored
    send("poke", 6'b101011, 2, 1'b0, 6'b0, 4'd1, 4);
    @(negedge clk);
    chk("poke_stays_idle", busy, 0);
    send("after_poke", 6'b101011, 1, 1'b0, 6'b0, 4'd0, -1);

    // Max repeat count: 16 copies, no wrap
    send("repmax", 6'b101011, 16, 1'b0, 6'b0, 4'd15, -1);

    // Load in IDLE, then start
    load_en = 1'b1; load_pat = 6'b110010;
    @(negedge clk);
    load_en = 1'b0;
    send("loaded", 6'b110010, 1, 1'b0, 6'b0, 4'd0, -1);

    // Load and start in the same cycle
    send("samecyc", 6'b011100, 1, 1'b1, 6'b011100, 4'd0, -1);

    // Abort on the 3rd valid bit (pattern now 011100)
    start = 1'b1; rep_cnt = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("ab_b0", out, 0);
    @(negedge clk);
    chk("ab_b1", out, 1);
    @(negedge clk);
    chk("ab_b2", out, 1);
    chk("ab_b2_valid", out_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_out", out, 0);
    @(negedge clk);
    chk("ab_nodone", done, 0);
    chk("ab_idle_busy", busy, 0);

    // Reset mid-copy restores the default pattern
    start = 1'b1; rep_cnt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("post_rst_nodone", done, 0);
    send("post_rst", 6'b101011, 1, 1'b0, 6'b0, 4'd0, -1);

    // Loopback into the detector: one detect per copy
    #1 det0 = det;
    @(negedge clk);
    send("loop", 6'b101011, 4, 1'b0, 6'b0, 4'd3, -1);
    #1;
    chk("loop_detects", det - det0, 4);
    chk("det_align", misal, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
